// File: rtl/tagged_regfile_pkg.sv
// Shared configuration for the tagged register file. The ROB and the
// reservation stations import the same widths, zero constants and tag type.
package tagged_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = $clog2(NREG_DEF);
  localparam int TAG_W_DEF = 4;
  localparam int NRD_DEF   = 2;

  localparam logic [XLEN_DEF-1:0] ZERO     = '0;
  localparam logic [AW_DEF-1:0]   ZERO_REG = '0;

  typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/tagged_regfile_if.sv
// Rename, commit and read-port bundle between issue/RS/ROB and the register file.
interface tagged_regfile_if
  import tagged_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = NRD_DEF
);

  logic                  flush;
  logic                  rn_en;
  logic [AW-1:0]         rn_rd;
  logic [TAG_W-1:0]      rn_tag;
  logic                  cm_en;
  logic [AW-1:0]         cm_rd;
  logic [TAG_W-1:0]      cm_tag;
  logic [XLEN-1:0]       cm_data;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NRD*TAG_W-1:0]  rd_tag;
  logic [AW:0]           busy_cnt;

  modport master (
    output flush, rn_en, rn_rd, rn_tag, cm_en, cm_rd, cm_tag, cm_data, rd_addr,
    input  rd_data, rd_busy, rd_tag, busy_cnt
  );

  modport slave (
    input  flush, rn_en, rn_rd, rn_tag, cm_en, cm_rd, cm_tag, cm_data, rd_addr,
    output rd_data, rd_busy, rd_tag, busy_cnt
  );

endinterface

// File: rtl/tagged_regfile_rdport.sv
// One combinational read port: register-0 decode, commit forwarding and
// fallback to the stored value/busy/tag.
module tagged_regfile_rdport
  import tagged_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                        hold_zero_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [NREG-1:0][XLEN-1:0]   regs_i,
  input  logic [NREG-1:0]             busy_i,
  input  logic [NREG-1:0][TAG_W-1:0]  tags_i,
  input  logic                        cm_en_i,
  input  logic [AW-1:0]               cm_rd_i,
  input  logic [TAG_W-1:0]            cm_tag_i,
  input  logic [XLEN-1:0]             cm_data_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        busy_o,
  output logic [TAG_W-1:0]            tag_o
);

  localparam logic [AW-1:0]   REG0  = AW'(ZERO_REG);
  localparam logic [XLEN-1:0] DATA0 = XLEN'(ZERO);

  logic cm_hit;
  logic fwd;

  assign cm_hit = cm_en_i && (cm_rd_i == addr_i);
  // A commit to an idle register, or one whose tag matches the pending producer,
  // is visible to readers in the same cycle.
  assign fwd    = cm_hit && (!busy_i[addr_i] || (tags_i[addr_i] == cm_tag_i));

  // NOTE: every output gets a default before the priority chain, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
    tag_o  = tags_i[addr_i];
    if (hold_zero_i || (addr_i == REG0)) begin
      data_o = DATA0;
      busy_o = 1'b0;
      tag_o  = '0;
    end else if (fwd) begin
      data_o = cm_data_i;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/tagged_regfile.sv
// Integer register file with per-register busy/tag scoreboard, commit
// forwarding on NRD read ports and a registered busy count.
module tagged_regfile
  import tagged_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = NRD_DEF
) (
  input logic             clk,
  input logic             rst,
  tagged_regfile_if.slave bus_if
);

  localparam logic [AW-1:0] REG0 = AW'(ZERO_REG);

  logic [NREG-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0] tags_q, tags_d;
  logic [AW:0]                busy_cnt_q, busy_cnt_d;

  logic cm_wr;
  logic rn_wr;

  assign cm_wr = bus_if.cm_en && (bus_if.cm_rd != REG0);
  assign rn_wr = bus_if.rn_en && !bus_if.flush && (bus_if.rn_rd != REG0);

  // Order matters: commit first, then flush clears busy, then rename overrides.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tags_d = tags_q;

    if (cm_wr) begin
      regs_d[bus_if.cm_rd] = bus_if.cm_data;
      if (busy_q[bus_if.cm_rd] && (tags_q[bus_if.cm_rd] == bus_if.cm_tag)) begin
        busy_d[bus_if.cm_rd] = 1'b0;
      end
    end

    if (bus_if.flush) begin
      busy_d = '0;
    end

    if (rn_wr) begin
      busy_d[bus_if.rn_rd] = 1'b1;
      tags_d[bus_if.rn_rd] = bus_if.rn_tag;
    end

    busy_cnt_d = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // NOTE: the storage array is reset along with the scoreboard because reads
  // right after reset must return zero, not whatever the flops powered up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      tags_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      tags_q     <= tags_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic [NRD-1:0][XLEN-1:0]  rd_data_w;
  logic [NRD-1:0]            rd_busy_w;
  logic [NRD-1:0][TAG_W-1:0] rd_tag_w;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    tagged_regfile_rdport #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .AW    (AW),
      .TAG_W (TAG_W)
    ) u_rdport (
      .hold_zero_i (rst),
      .addr_i      (bus_if.rd_addr[k*AW +: AW]),
      .regs_i      (regs_q),
      .busy_i      (busy_q),
      .tags_i      (tags_q),
      .cm_en_i     (bus_if.cm_en),
      .cm_rd_i     (bus_if.cm_rd),
      .cm_tag_i    (bus_if.cm_tag),
      .cm_data_i   (bus_if.cm_data),
      .data_o      (rd_data_w[k]),
      .busy_o      (rd_busy_w[k]),
      .tag_o       (rd_tag_w[k])
    );
  end

  assign bus_if.rd_data  = rd_data_w;
  assign bus_if.rd_busy  = rd_busy_w;
  assign bus_if.rd_tag   = rd_tag_w;
  assign bus_if.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_tagged_regfile.sv
// Scoreboard bench for tagged_regfile: directed scenarios plus a randomized
// run against a behavioural model of the scoreboard.
module tb_tagged_regfile;
  import tagged_regfile_pkg::*;

  localparam int XLEN  = XLEN_DEF;
  localparam int NREG  = NREG_DEF;
  localparam int AW    = AW_DEF;
  localparam int TAG_W = TAG_W_DEF;
  localparam int NRD   = NRD_DEF;

  // port >= 0: read port expectation; port < 0: busy_cnt expectation in data
  typedef struct {
    string           name;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    tag_t            tag;
    bit              chk_tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic rst;

  tagged_regfile_if #(.XLEN(XLEN), .AW(AW), .TAG_W(TAG_W), .NRD(NRD)) rf_if ();

  tagged_regfile #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .TAG_W(TAG_W), .NRD(NRD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (rf_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    rf_if.flush   = 1'b0;
    rf_if.rn_en   = 1'b0;
    rf_if.rn_rd   = '0;
    rf_if.rn_tag  = '0;
    rf_if.cm_en   = 1'b0;
    rf_if.cm_rd   = '0;
    rf_if.cm_tag  = '0;
    rf_if.cm_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input int port, input logic [AW-1:0] addr);
    rf_if.rd_addr[port*AW +: AW] = addr;
  endtask

  task automatic rename(input logic [AW-1:0] rd, input tag_t tag);
    rf_if.rn_en  = 1'b1;
    rf_if.rn_rd  = rd;
    rf_if.rn_tag = tag;
  endtask

  task automatic commit(input logic [AW-1:0] rd, input tag_t tag, input logic [XLEN-1:0] data);
    rf_if.cm_en   = 1'b1;
    rf_if.cm_rd   = rd;
    rf_if.cm_tag  = tag;
    rf_if.cm_data = data;
  endtask

  task automatic expect_read(input string name, input int port, input logic [XLEN-1:0] data,
                             input logic busy, input tag_t tag, input bit chk_tag);
    exp_t e;
    e.name = name; e.port = port; e.data = data; e.busy = busy; e.tag = tag; e.chk_tag = chk_tag;
    sb_q.push_back(e);
  endtask

  task automatic expect_cnt(input string name, input int cnt);
    exp_t e;
    e.name = name; e.port = -1; e.data = XLEN'(cnt); e.busy = 1'b0; e.tag = '0; e.chk_tag = 1'b0;
    sb_q.push_back(e);
  endtask

  // Pops every pending expectation and compares it with what the DUT drives now.
  task automatic scoreboard_drain();
    exp_t            e;
    logic [XLEN-1:0] a_data;
    logic            a_busy;
    tag_t            a_tag;
    logic [AW:0]     a_cnt;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (e.port < 0) begin
        a_cnt = rf_if.busy_cnt;
        if (a_cnt !== e.data[AW:0]) begin
          bad++;
          $display("FAIL %s busy_cnt: got %0d want %0d", e.name, a_cnt, e.data[AW:0]);
        end
      end else begin
        a_data = rf_if.rd_data[e.port*XLEN +: XLEN];
        a_busy = rf_if.rd_busy[e.port];
        a_tag  = rf_if.rd_tag[e.port*TAG_W +: TAG_W];
        if ((a_data !== e.data) || (a_busy !== e.busy) || (e.chk_tag && (a_tag !== e.tag))) begin
          bad++;
          $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h%s",
                   e.name, e.port, a_data, a_busy, a_tag, e.data, e.busy, e.tag,
                   e.chk_tag ? "" : " (tag not checked)");
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    commit(5'd3, 4'd0, 32'hFFFF_FFFF);
    set_read(0, 5'd3);
    set_read(1, 5'd0);
    #2;
    expect_read("rst_hold_fwd", 0, '0, 1'b0, '0, 1'b1);
    expect_read("rst_hold_x0", 1, '0, 1'b0, '0, 1'b1);
    expect_cnt("rst_hold", 0);
    scoreboard_drain();
    #11 rst = 1'b0;
    idle();

    step();
    rename(5'd4, 4'd5);
    set_read(0, 5'd4);
    @(negedge clk);
    expect_read("pre_rename_x4", 0, '0, 1'b0, '0, 1'b0);
    scoreboard_drain();

    step();
    idle();
    rename(5'd6, 4'd2);
    commit(5'd8, 4'd0, 32'h99);
    set_read(0, 5'd4);
    set_read(1, 5'd8);
    @(negedge clk);
    expect_read("busy_x4", 0, '0, 1'b1, 4'd5, 1'b1);
    expect_read("fwd_idle_x8", 1, 32'h99, 1'b0, '0, 1'b0);
    expect_cnt("cnt_one", 1);
    scoreboard_drain();

    step();
    idle();
    set_read(0, 5'd6);
    set_read(1, 5'd8);
    @(negedge clk);
    expect_read("busy_x6", 0, '0, 1'b1, 4'd2, 1'b1);
    expect_read("stored_x8", 1, 32'h99, 1'b0, '0, 1'b0);
    expect_cnt("cnt_two", 2);
    scoreboard_drain();

    // asynchronous reset in the middle of a cycle with a live commit
    @(posedge clk);
    #3;
    commit(5'd8, 4'd0, 32'h1234);
    set_read(0, 5'd4);
    set_read(1, 5'd8);
    rst = 1'b1;
    #1;
    expect_read("async_rst_x4", 0, '0, 1'b0, '0, 1'b1);
    expect_read("async_rst_x8", 1, '0, 1'b0, '0, 1'b1);
    expect_cnt("async_rst", 0);
    scoreboard_drain();

    @(posedge clk);
    #3;
    rst = 1'b0;
    idle();
    set_read(0, 5'd8);
    set_read(1, 5'd6);
    #1;
    expect_read("post_rst_x8", 0, '0, 1'b0, '0, 1'b0);
    expect_read("post_rst_x6", 1, '0, 1'b0, '0, 1'b0);
    scoreboard_drain();
  endtask

  task automatic test_rename_commit();
    step();
    idle();
    rename(5'd5, 4'd3);
    set_read(0, 5'd5);
    @(negedge clk);
    expect_read("t2_pre", 0, '0, 1'b0, '0, 1'b0);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t2_busy", 0, '0, 1'b1, 4'd3, 1'b1);
    expect_cnt("t2_cnt1", 1);
    scoreboard_drain();

    step();
    commit(5'd5, 4'd3, 32'hDEAD_BEEF);
    set_read(1, 5'd5);
    @(negedge clk);
    expect_read("t2_fwd_p0", 0, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    expect_read("t2_fwd_p1", 1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    expect_cnt("t2_cnt_still1", 1);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t2_stored", 0, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    expect_cnt("t2_cnt0", 0);
    scoreboard_drain();
  endtask

  task automatic test_stale_tag();
    step();
    idle();
    rename(5'd7, 4'd1);
    step();
    rename(5'd7, 4'd2);
    step();
    idle();
    commit(5'd7, 4'd1, 32'h11);
    set_read(0, 5'd7);
    @(negedge clk);
    expect_read("t3_stale_nofwd", 0, '0, 1'b1, 4'd2, 1'b1);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t3_data_written", 0, 32'h11, 1'b1, 4'd2, 1'b1);
    expect_cnt("t3_cnt1", 1);
    scoreboard_drain();

    step();
    commit(5'd7, 4'd2, 32'h22);
    @(negedge clk);
    expect_read("t3_match_fwd", 0, 32'h22, 1'b0, '0, 1'b0);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t3_cleared", 0, 32'h22, 1'b0, '0, 1'b0);
    expect_cnt("t3_cnt0", 0);
    scoreboard_drain();
  endtask

  task automatic test_rename_commit_same();
    step();
    idle();
    rename(5'd9, 4'd6);
    step();
    rename(5'd9, 4'd4);
    commit(5'd9, 4'd6, 32'h55);
    set_read(0, 5'd9);
    @(negedge clk);
    expect_read("t4_same_cycle", 0, 32'h55, 1'b0, '0, 1'b0);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t4_rename_wins", 0, 32'h55, 1'b1, 4'd4, 1'b1);
    expect_cnt("t4_cnt1", 1);
    scoreboard_drain();

    step();
    commit(5'd9, 4'd4, 32'h66);
    step();
    idle();
    @(negedge clk);
    expect_read("t4_done", 0, 32'h66, 1'b0, '0, 1'b0);
    expect_cnt("t4_cnt0", 0);
    scoreboard_drain();
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 10; r++) begin
      step();
      idle();
      rename(AW'(r), TAG_W'(r));
    end
    step();
    idle();
    set_read(0, 5'd2);
    set_read(1, 5'd10);
    @(negedge clk);
    expect_read("t5_x2_busy", 0, '0, 1'b1, 4'd2, 1'b1);
    expect_read("t5_x10_busy", 1, '0, 1'b1, 4'd10, 1'b1);
    expect_cnt("t5_cnt10", 10);
    scoreboard_drain();

    step();
    rf_if.flush = 1'b1;
    rename(5'd11, 4'd7);
    commit(5'd2, 4'd2, 32'hA);
    set_read(1, 5'd11);
    @(negedge clk);
    expect_read("t5_fwd_x2", 0, 32'hA, 1'b0, '0, 1'b0);
    expect_read("t5_x11_pre", 1, '0, 1'b0, '0, 1'b0);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t5_x2_after", 0, 32'hA, 1'b0, '0, 1'b0);
    expect_read("t5_x11_dropped", 1, '0, 1'b0, '0, 1'b0);
    expect_cnt("t5_cnt0", 0);
    scoreboard_drain();
    set_read(0, 5'd5);
    set_read(1, 5'd1);
    #1;
    expect_read("t5_x5_clear", 0, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    expect_read("t5_x1_clear", 1, '0, 1'b0, '0, 1'b0);
    scoreboard_drain();
  endtask

  task automatic test_zero_reg();
    step();
    idle();
    rename(5'd12, 4'd3);
    step();
    rename(5'd0, 4'd9);
    commit(5'd0, 4'd0, 32'hFFFF_FFFF);
    set_read(0, 5'd0);
    set_read(1, 5'd0);
    @(negedge clk);
    expect_read("t6_x0_p0", 0, '0, 1'b0, '0, 1'b0);
    expect_read("t6_x0_p1", 1, '0, 1'b0, '0, 1'b0);
    expect_cnt("t6_cnt1", 1);
    scoreboard_drain();

    step();
    idle();
    @(negedge clk);
    expect_read("t6_x0_after", 0, '0, 1'b0, '0, 1'b0);
    expect_cnt("t6_cnt_unchanged", 1);
    scoreboard_drain();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] m_regs [NREG];
    tag_t            m_tag  [NREG];
    logic [NREG-1:0] m_busy;
    logic [AW-1:0]   a;
    logic [AW-1:0]   c_rd;
    logic [AW-1:0]   r_rd;
    tag_t            c_tag;

    step();
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_tag[i]  = '0;
    end
    m_busy = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      r_rd  = AW'($urandom_range(0, 15));
      c_rd  = AW'($urandom_range(0, 15));
      c_tag = ($urandom_range(0, 3) != 0) ? m_tag[c_rd] : TAG_W'($urandom);
      rf_if.rn_en   = ($urandom_range(0, 2) != 0);
      rf_if.rn_rd   = r_rd;
      rf_if.rn_tag  = TAG_W'($urandom);
      rf_if.cm_en   = ($urandom_range(0, 1) != 0);
      rf_if.cm_rd   = c_rd;
      rf_if.cm_tag  = c_tag;
      rf_if.cm_data = $urandom;
      rf_if.flush   = ($urandom_range(0, 19) == 0);

      for (int k = 0; k < NRD; k++) begin
        a = ($urandom_range(0, 2) == 0) ? c_rd : AW'($urandom_range(0, 15));
        set_read(k, a);
        if (a == '0)
          expect_read("rnd_x0", k, '0, 1'b0, '0, 1'b0);
        else if (rf_if.cm_en && (c_rd == a) && (!m_busy[a] || (m_tag[a] == c_tag)))
          expect_read("rnd_fwd", k, rf_if.cm_data, 1'b0, '0, 1'b0);
        else
          expect_read("rnd_store", k, m_regs[a], m_busy[a], m_tag[a], m_busy[a]);
      end
      expect_cnt("rnd_cnt", $countones(m_busy));

      @(negedge clk);
      scoreboard_drain();

      if (rf_if.cm_en && (c_rd != '0)) begin
        m_regs[c_rd] = rf_if.cm_data;
        if (m_busy[c_rd] && (m_tag[c_rd] == c_tag)) m_busy[c_rd] = 1'b0;
      end
      if (rf_if.flush) begin
        m_busy = '0;
      end else if (rf_if.rn_en && (r_rd != '0)) begin
        m_busy[r_rd] = 1'b1;
        m_tag[r_rd]  = rf_if.rn_tag;
      end
    end
    step();
    idle();
  endtask

  initial begin
    rf_if.rd_addr = '0;
    test_reset();
    test_rename_commit();
    test_stale_tag();
    test_rename_commit_same();
    test_flush();
    test_zero_reg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
